// File: rtl/ffd_pkg.sv
// Shared definitions for the FFD shift-register slice: shift directions,
// the default width, and the per-bit next-state selection helper.
package ffd_pkg;

  localparam logic DIR_LEFT      = 1'b0;
  localparam logic DIR_RIGHT     = 1'b1;
  localparam int   DEFAULT_WIDTH = 4;

  // Next value of one register bit: load wins, then shift in the sampled direction, else hold.
  function automatic logic ffd_next_bit(
    input logic load,
    input logic shift,
    input logic dir,
    input logic load_bit,
    input logic left_bit,
    input logic right_bit,
    input logic hold_bit
  );
    logic nb;
    if (load) begin
      nb = load_bit;
    end else if (shift) begin
      if (dir == DIR_RIGHT) begin
        nb = right_bit;
      end else begin
        nb = left_bit;
      end
    end else begin
      nb = hold_bit;
    end
    return nb;
  endfunction

endpackage

// File: rtl/ffd_cell.sv
// One-bit D flip-flop with clock enable and asynchronous active-low reset;
// the building block of each shift-register stage.
module ffd_cell (
  input  logic clk,
  input  logic reset,
  input  logic enabled,
  input  logic D,
  output logic Q
);

  // Storage bit: cleared by reset, captures D only while enabled.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      Q <= 1'b0;
    end else if (enabled) begin
      Q <= D;
    end else begin
      Q <= Q;
    end
  end

endmodule

// File: rtl/ffd_shift_reg.sv
// Bidirectional shift register with parallel load, built from ffd_cell stages,
// plus a saturating shift counter and a registered full-word flag.
module ffd_shift_reg
  import ffd_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enabled,
  input  logic             load,
  input  logic             shift,
  input  logic             dir,
  input  logic             sin,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             sout,
  output logic [CNT_W-1:0] cnt,
  output logic             done
);

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;
  logic [WIDTH-1:0] left_s;
  logic [WIDTH-1:0] right_s;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             done_q;
  logic             done_d;

  assign left_s  = {q_q[WIDTH-2:0], sin};
  assign right_s = {sin, q_q[WIDTH-1:1]};

  // Per-bit next-state mux feeding each cell's D input.
  always_comb begin
    q_d = q_q;
    for (int i = 0; i < WIDTH; i++) begin
      q_d[i] = ffd_next_bit(load, shift, dir, d[i], left_s[i], right_s[i], q_q[i]);
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_cell
      ffd_cell u_cell (
        .clk     (clk),
        .reset   (reset),
        .enabled (enabled),
        .D       (q_d[gi]),
        .Q       (q_q[gi])
      );
    end
  endgenerate

  // Counter and full-word flag next state; the counter stops at WIDTH rather than wrapping.
  always_comb begin
    cnt_d  = cnt_q;
    done_d = done_q;
    if (load) begin
      cnt_d  = {CNT_W{1'b0}};
      done_d = 1'b0;
    end else if (shift && (cnt_q != CNT_FULL)) begin
      cnt_d  = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
      done_d = (cnt_q == CNT_LAST) ? 1'b1 : done_q;
    end else begin
      cnt_d  = cnt_q;
      done_d = done_q;
    end
  end

  // Counter and flag registers, sharing the cells' enable and reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q  <= {CNT_W{1'b0}};
      done_q <= 1'b0;
    end else if (enabled) begin
      cnt_q  <= cnt_d;
      done_q <= done_d;
    end else begin
      cnt_q  <= cnt_q;
      done_q <= done_q;
    end
  end

  assign q    = q_q;
  assign sout = (dir == DIR_RIGHT) ? q_q[0] : q_q[WIDTH-1];
  assign cnt  = cnt_q;
  assign done = done_q;

endmodule
